// File: rtl/divider_cfg_arbiter.sv
// Round-robin arbiter that shares one even clock divider between NREQ requesters and
// sequences each ratio change as: wait for div_out low, disable, settle, load N, re-enable.
module divider_cfg_arbiter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned SETTLE  = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_n,
  input  logic                    div_out,
  output logic [WIDTH-1:0]        div_n,
  output logic                    div_en,
  output logic [NREQ-1:0]         grant,
  output logic                    err,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] owner
);

  localparam int unsigned IdxW   = $clog2(NREQ);
  localparam int unsigned CntMax = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    StIdle,
    StResp,
    StWaitLow,
    StSettle,
    StLoad,
    StEnable
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   win_q, win_d;
  logic [WIDTH-1:0]  pend_q, pend_d;
  logic              err_pend_q, err_pend_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  div_n_q, div_n_d;
  logic              div_en_q, div_en_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [IdxW-1:0]   owner_q, owner_d;

  // Round-robin pick: first set request scanning upward from the pointer, wrapping.
  logic              found;
  logic [IdxW-1:0]   win_c;
  logic [IdxW-1:0]   ptr_nxt_c;
  logic [WIDTH-1:0]  win_n_c;
  int                idx;

  always_comb begin
    found     = 1'b0;
    win_c     = ptr_q;
    ptr_nxt_c = ptr_q;
    win_n_c   = '0;
    idx       = 0;
    for (int o = 0; o < int'(NREQ); o++) begin
      idx = (int'(ptr_q) + o) % int'(NREQ);
      if (!found && req[idx]) begin
        found     = 1'b1;
        win_c     = IdxW'(idx);
        ptr_nxt_c = IdxW'((idx + 1) % int'(NREQ));
        win_n_c   = req_n[idx*int'(WIDTH) +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    pend_d     = pend_q;
    err_pend_d = err_pend_q;
    cnt_d      = cnt_q;
    div_n_d    = div_n_q;
    div_en_d   = div_en_q;
    grant_d    = '0;
    err_d      = 1'b0;
    busy_d     = busy_q;
    owner_d    = owner_q;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          win_d  = win_c;
          pend_d = win_n_c;
          ptr_d  = ptr_nxt_c;
          busy_d = 1'b1;
          if (win_n_c == '0) begin
            err_pend_d = 1'b1;
            state_d    = StResp;
          end else if (win_n_c == div_n_q && div_en_q) begin
            err_pend_d = 1'b0;
            state_d    = StResp;
          end else begin
            err_pend_d = 1'b0;
            cnt_d      = '0;
            state_d    = StWaitLow;
          end
        end
      end

      StResp: begin
        grant_d[win_q] = 1'b1;
        err_d          = err_pend_q;
        busy_d         = 1'b0;
        state_d        = StIdle;
      end

      StWaitLow: begin
        // A disabled divider is already safe to reprogram; a stuck-high one is forced.
        if (!div_out || !div_en_q) begin
          div_en_d = 1'b0;
          cnt_d    = '0;
          state_d  = StSettle;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          div_en_d   = 1'b0;
          err_pend_d = 1'b1;
          cnt_d      = '0;
          state_d    = StSettle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StSettle: begin
        if (cnt_q == CntW'(SETTLE - 1)) begin
          cnt_d   = '0;
          state_d = StLoad;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StLoad: begin
        div_n_d = pend_q;
        owner_d = win_q;
        state_d = StEnable;
      end

      StEnable: begin
        div_en_d       = 1'b1;
        grant_d[win_q] = 1'b1;
        err_d          = err_pend_q;
        busy_d         = 1'b0;
        state_d        = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      win_q      <= '0;
      pend_q     <= '0;
      err_pend_q <= 1'b0;
      cnt_q      <= '0;
      div_n_q    <= '0;
      div_en_q   <= 1'b0;
      grant_q    <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      owner_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      pend_q     <= pend_d;
      err_pend_q <= err_pend_d;
      cnt_q      <= cnt_d;
      div_n_q    <= div_n_d;
      div_en_q   <= div_en_d;
      grant_q    <= grant_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      owner_q    <= owner_d;
    end
  end

  assign div_n  = div_n_q;
  assign div_en = div_en_q;
  assign grant  = grant_q;
  assign err    = err_q;
  assign busy   = busy_q;
  assign owner  = owner_q;

endmodule

// File: tb/tb_divider_cfg_arbiter.sv
// Self-checking bench for divider_cfg_arbiter: directed table, randomized transactions
// against a timeline reference model, reset-during-settle and held-request sequences.
module tb_divider_cfg_arbiter;

  localparam int W   = 8;
  localparam int NR  = 4;
  localparam int SET = 2;
  localparam int TO  = 16;

  logic                  clk;
  logic                  reset_n;
  logic [NR-1:0]         req;
  logic [NR*W-1:0]       req_n;
  logic                  div_out;
  logic [W-1:0]          div_n;
  logic                  div_en;
  logic [NR-1:0]         grant;
  logic                  err;
  logic                  busy;
  logic [$clog2(NR)-1:0] owner;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: round-robin pointer and what the divider is programmed to.
  int         m_ptr;
  logic [W-1:0] m_n;
  logic       m_en;
  int         m_owner;

  divider_cfg_arbiter #(
    .WIDTH  (W),
    .NREQ   (NR),
    .SETTLE (SET),
    .TIMEOUT(TO)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .req    (req),
    .req_n  (req_n),
    .div_out(div_out),
    .div_n  (div_n),
    .div_en (div_en),
    .grant  (grant),
    .err    (err),
    .busy   (busy),
    .owner  (owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_n     = '0;
    m_en    = 1'b0;
    m_owner = 0;
  endtask

  // Presents one request set from IDLE and checks every output on every cycle until the
  // cycle after the grant. s = number of WAIT_LOW sample edges that see div_out high.
  task automatic run_txn(input logic [NR-1:0] r, input logic [NR*W-1:0] ns, input int s,
                         output int win_o, output int g_o, output logic err_o);
    int           win, d, g, t_off, t_load, exp_own;
    logic [W-1:0] pend, exp_n;
    logic         sw, e_err, exp_en;
    logic [NR-1:0] exp_g;
    logic [16:0]  exp_v, act_v;

    win = -1;
    for (int o = 0; o < NR; o++) begin
      int i;
      i = (m_ptr + o) % NR;
      if (win < 0 && r[i]) win = i;
    end
    pend  = ns[win*W +: W];
    sw    = 1'b0;
    d     = 0;
    e_err = 1'b0;
    if (pend == 0) begin
      e_err = 1'b1;
    end else if (pend == m_n && m_en) begin
      e_err = 1'b0;
    end else begin
      sw = 1'b1;
      if (m_en) begin
        d     = (s < TO) ? s : TO - 1;
        e_err = (s >= TO);
      end
    end
    g      = sw ? 3 + SET + d : 1;
    t_off  = 1 + d;
    t_load = 2 + SET + d;

    req     = r;
    req_n   = ns;
    div_out = (s > 0);
    step();
    req   = '0;
    req_n = $urandom;
    g_o   = -1;
    win_o = -1;
    err_o = 1'b0;
    for (int e = 0; e <= g + 1; e++) begin
      if (e > 0) step();
      div_out = (e + 1 <= s);
      if (sw) begin
        exp_en  = (e < t_off) ? m_en : ((e < g) ? 1'b0 : 1'b1);
        exp_n   = (e < t_load) ? m_n : pend;
        exp_own = (e < t_load) ? m_owner : win;
      end else begin
        exp_en  = m_en;
        exp_n   = m_n;
        exp_own = m_owner;
      end
      exp_g = '0;
      if (e == g) exp_g[win] = 1'b1;
      exp_v = {(e < g), exp_g, (e == g) && e_err, exp_en, exp_n, 2'(exp_own)};
      act_v = {busy, grant, err, div_en, div_n, owner};
      check("txn_cycle", act_v, exp_v);
      if (grant != '0 && g_o < 0) begin
        g_o   = e;
        err_o = err;
        for (int b = 0; b < NR; b++) if (grant[b]) win_o = b;
      end
    end

    m_ptr = (win + 1) % NR;
    if (sw) begin
      m_n     = pend;
      m_en    = 1'b1;
      m_owner = win;
    end
  endtask

  typedef struct {
    logic [NR-1:0]   r;
    logic [NR*W-1:0] ns;
    int              s;
    int              win;
    int              g;
    logic            e;
    logic [W-1:0]    n;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int          win_o, g_o, s, ng;
    logic        err_o;
    logic [NR-1:0] r, prev;
    logic [NR*W-1:0] ns;
    logic [W-1:0]  v;
    logic [NR-1:0] held_seq [3];

    // Expected winner, grant latency (edges after acceptance), err and final div_n.
    tbl[0] = '{4'b0001, {8'd0, 8'd0, 8'd0, 8'd4}, 0,  0, 5,  1'b0, 8'd4};
    tbl[1] = '{4'b0010, {8'd0, 8'd0, 8'd6, 8'd0}, 3,  1, 8,  1'b0, 8'd6};
    tbl[2] = '{4'b1000, {8'd0, 8'd0, 8'd0, 8'd0}, 0,  3, 1,  1'b1, 8'd6};
    tbl[3] = '{4'b0100, {8'd0, 8'd6, 8'd0, 8'd0}, 0,  2, 1,  1'b0, 8'd6};
    tbl[4] = '{4'b0101, {8'd0, 8'd7, 8'd0, 8'd5}, 0,  0, 5,  1'b0, 8'd5};
    tbl[5] = '{4'b0101, {8'd0, 8'd7, 8'd0, 8'd5}, 0,  2, 5,  1'b0, 8'd7};
    tbl[6] = '{4'b1111, {8'd9, 8'd9, 8'd9, 8'd9}, 20, 3, 20, 1'b1, 8'd9};
    tbl[7] = '{4'b0001, {8'd0, 8'd0, 8'd0, 8'd9}, 0,  0, 1,  1'b0, 8'd9};

    reset_n = 1'b0;
    req     = '0;
    req_n   = '0;
    div_out = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {busy, grant, err, div_en, div_n, owner}, '0);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i].r, tbl[i].ns, tbl[i].s, win_o, g_o, err_o);
      check("tbl_win", win_o, tbl[i].win);
      check("tbl_grant_latency", g_o, tbl[i].g);
      check("tbl_err", err_o, tbl[i].e);
      check("tbl_div_n", div_n, tbl[i].n);
    end

    for (int it = 0; it < 30; it++) begin
      r = NR'($urandom_range(1, 15));
      for (int i = 0; i < NR; i++) begin
        case ($urandom_range(0, 3))
          0:       v = '0;
          1:       v = m_n;
          default: v = W'($urandom_range(1, 15));
        endcase
        ns[i*W +: W] = v;
      end
      if ($urandom_range(0, 4) == 0) s = $urandom_range(14, 19);
      else s = $urandom_range(0, 4);
      run_txn(r, ns, s, win_o, g_o, err_o);
    end

    // Reset asserted while the divider is held disabled in the settle window.
    req     = 4'b0010;
    req_n   = {8'd0, 8'd0, 8'd200, 8'd0};
    div_out = 1'b0;
    step();
    req = '0;
    step();
    step();
    check("settle_busy_en", {busy, div_en}, 2'b10);
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_mid_settle", {busy, grant, err, div_en, div_n, owner}, '0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    for (int c = 0; c < 6; c++) begin
      step();
      check("post_reset_idle", {busy, grant, err, div_en, div_n, owner}, '0);
    end

    // Two requesters held high together alternate 0, 2, 0.
    held_seq[0] = 4'b0001;
    held_seq[1] = 4'b0100;
    held_seq[2] = 4'b0001;
    req     = 4'b0101;
    req_n   = {8'd0, 8'd8, 8'd0, 8'd4};
    div_out = 1'b0;
    prev    = '0;
    ng      = 0;
    for (int c = 0; c < 80 && ng < 3; c++) begin
      step();
      if (grant != '0) begin
        check("held_onehot", $onehot(grant), 1'b1);
        check("held_order", grant, held_seq[ng]);
        check("held_pulse", prev, '0);
        ng++;
      end
      prev = grant;
    end
    req = '0;
    check("held_count", ng, 3);
    step();
    check("held_pulse_end", grant, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
